// File: rtl/imem_loader_pkg.sv
// loader_pkg: shared types and constants for the instruction-memory boot loader.
//   loader_state_e  : loader FSM states
//   WORD_W          : instruction word width in bits
//   BYTES_PER_WORD  : stream bytes packed into one instruction word
package loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write bus.
//   byte_valid/byte_data : stream byte offered by the source
//   byte_ready           : loader accepts a byte this cycle
//   imem_we/addr/wdata   : registered one-cycle write to instruction memory
// master = byte source / memory side, slave = loader.
interface imem_loader_if
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles stream bytes little-endian into 32-bit words.
//   clk, reset  : clock, async active-high reset
//   clear       : restart packing at byte 0 (start of a load)
//   load        : a data byte is accepted this cycle
//   in_byte     : the data byte
//   word_ready  : this byte completes a word (combinational, same cycle)
//   word_next   : the completed word, valid while word_ready is high
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        in_byte,
  output logic              word_ready,
  output logic [WORD_W-1:0] word_next
);

  logic [1:0]        idx;
  // Only the upper three bytes need storing: each new byte enters at the
  // top and the oldest drops off the bottom, so byte 0 ends in bits 7:0.
  logic [WORD_W-9:0] shreg;

  assign word_next  = {in_byte, shreg};
  assign word_ready = load && (idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx   <= '0;
      shreg <= '0;
    end else if (clear) begin
      idx   <= '0;
      shreg <= '0;
    end else if (load) begin
      idx   <= idx + 2'd1;
      shreg <= word_next[WORD_W-1:8];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for instruction memory.
// Stream: count byte N, N*4 data bytes (little-endian words), checksum byte
// (8-bit sum of data bytes). Holds cpu_reset until a verified image lands.
//   clk, reset : clock, async active-high reset
//   start      : begin a load (honoured in IDLE, DONE, ERR only)
//   bus        : byte stream in, instruction-memory writes out
//   cpu_reset  : core held in reset unless the last load succeeded
//   busy       : load in progress
//   done / err : last load succeeded / failed
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

  loader_state_e     state;
  logic [7:0]        word_total;
  logic [7:0]        word_cnt;
  logic [7:0]        sum;
  logic [ADDR_W-1:0] waddr;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [WORD_W-1:0] wdata_r;

  logic              accept;
  logic              restart;
  logic              pack_load;
  logic              word_ready;
  logic [WORD_W-1:0] word_next;

  // Status comes straight from the state register, so done/err/busy and
  // cpu_reset all change on the same edge as the state itself.
  assign busy       = (state == COUNT) || (state == DATA) || (state == CSUM);
  assign done       = (state == DONE);
  assign err        = (state == ERR);
  assign cpu_reset  = !done;

  assign accept     = bus.byte_valid && busy;
  assign restart    = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign pack_load  = accept && (state == DATA);

  assign bus.byte_ready = busy;
  assign bus.imem_we    = we_r;
  assign bus.imem_addr  = addr_r;
  assign bus.imem_wdata = wdata_r;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .load       (pack_load),
    .in_byte    (bus.byte_data),
    .word_ready (word_ready),
    .word_next  (word_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      word_total <= '0;
      word_cnt   <= '0;
      sum        <= '0;
      waddr      <= '0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
    end else begin
      we_r <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (restart) begin
            state    <= COUNT;
            word_cnt <= '0;
            sum      <= '0;
            waddr    <= '0;
          end
        end
        COUNT: begin
          if (accept) begin
            if ((bus.byte_data == 8'd0) || ({1'b0, bus.byte_data} > DEPTH_L)) begin
              state <= ERR;
            end else begin
              word_total <= bus.byte_data;
              state      <= DATA;
            end
          end
        end
        DATA: begin
          if (pack_load) begin
            sum <= sum + bus.byte_data;
            if (word_ready) begin
              we_r     <= 1'b1;
              addr_r   <= waddr;
              wdata_r  <= word_next;
              waddr    <= waddr + ADDR_W'(1);
              word_cnt <= word_cnt + 8'd1;
              if ((word_cnt + 8'd1) == word_total) state <= CSUM;
            end
          end
        end
        CSUM: begin
          if (accept) state <= (bus.byte_data == sum) ? DONE : ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the processor's instruction memory. Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instruction words, and writes them to consecutive word addresses of instruction memory. Holds the core in reset (`cpu_reset`) until a complete, checksum-verified image has been written, then releases it so the program counter starts fetching from word 0.

## Interface

Parameters:

- `ADDR_W`, 8: width of the instruction-memory word address.
- `DEPTH`, 64: number of instruction words. A count byte above `DEPTH` is rejected.

Ports (clock and reset first):

- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `start` input 1: begin a load. Sampled only in IDLE, DONE or ERR.
- `byte_valid` input 1: source has a byte on `byte_data`.
- `byte_data` input 8: stream byte.
- `byte_ready` output 1: loader can accept a byte this cycle.
- `imem_we` output 1: one-cycle write strobe to instruction memory.
- `imem_addr` output ADDR_W: word address for the write.
- `imem_wdata` output 32: instruction word for the write.
- `cpu_reset` output 1: holds the core in reset; high unless a load has succeeded.
- `busy` output 1: a load is in progress.
- `done` output 1: last load succeeded.
- `err` output 1: last load failed.

## Operation

- Stream format, in order:
  - Count byte N: the number of words.
  - N×4 data bytes, each word little-endian (byte 0 is bits 7:0).
  - Checksum byte: the 8-bit wrapping sum of the data bytes only. The count byte is excluded.
- A byte is accepted on any edge where `byte_valid && byte_ready`.
- States and transitions:
  - IDLE: `start` → COUNT.
  - COUNT: on accept, N==0 or N>DEPTH → ERR; otherwise latch N → DATA.
  - DATA: on accept, shift the byte into the word register and add it to the running sum; increment the byte index (0–3). Byte index 3 → issue a write. When the last word is accepted → CSUM.
  - CSUM: on accept, checksum match → DONE, mismatch → ERR.
  - DONE: `start` → COUNT. The restart clears `done` and raises `cpu_reset`.
  - ERR: `start` → COUNT. The restart clears `err`.
- `byte_ready` is high exactly in COUNT, DATA and CSUM. It does not depend on `byte_valid`.
- Word address starts at 0 on every load and increments after each write. It never wraps, because N ≤ DEPTH.
- `start` while busy is ignored.
- In ERR, `cpu_reset` stays high. Memory contents are left partially written.
- Arithmetic widths:
  - Running sum: 8 bits, mod 256.
  - Word counter: 8 bits.
  - Byte index: 2 bits.

## Timing

- Reset values:
  - State = IDLE.
  - `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `cpu_reset`=1, `busy`=0, `done`=0, `err`=0.
- `busy` rises one cycle after `start` is sampled, together with `byte_ready`.
- Write latency: `imem_we`, `imem_addr` and `imem_wdata` are registered. They are valid for exactly one cycle, starting the cycle after the edge that accepts the word's 4th byte.
  - A new byte may be accepted in that same cycle, so full throughput is 1 byte per cycle.
- `done` or `err` rises one cycle after the edge that accepts the checksum byte (or the bad count byte). `busy` and `byte_ready` fall in that same cycle.
- `cpu_reset` falls in the same cycle that `done` rises.
- Gaps in `byte_valid` stall progress with no effect on state or data.
- Reset mid-load aborts immediately: no further `imem_we`, and all outputs return to their reset values.

## Structure

- Shared package `loader_pkg`:
  - State enum (IDLE, COUNT, DATA, CSUM, DONE, ERR).
  - Word width constant 32.
  - Bytes-per-word constant 4.
- One natural sub-module, `byte_packer`:
  - 2-bit byte index and 32-bit shift/assembly register.
  - Pulses `word_ready` when the 4th byte lands.
  - Cleared at the start of each load.
- The FSM, counters and checksum live in `imem_loader`.

## Test plan

- Good 2-word load: `start`, then bytes 02, 93 00 50 00, 13 81 30 00, A7.
  - Expect `imem_we` pulses at addr 0 with 0x00500093 and at addr 1 with 0x00308113.
  - Then `done`=1 and `cpu_reset`=0, one cycle after the A7 byte is accepted.
- Bad checksum: the same stream with final byte A6.
  - Both words are written, then `err`=1, `done`=0, and `cpu_reset` stays 1.
- Bad count: count byte 00, then (in a separate run) count 41 with DEPTH=64.
  - Each gives `err`=1 the next cycle, with no `imem_we` at all.
- Backpressure and gaps: the good stream with `byte_valid` toggling randomly.
  - Expect the same writes and result as the good load; no byte is dropped or duplicated.
- Reset mid-load: assert `reset` after the 3rd data byte.
  - All outputs return to their reset values immediately, with no `imem_we`.
  - A following good load succeeds.
- `start` while busy: pulse `start` during DATA.
  - No effect on state; the addresses continue 0, 1.
- Reload from DONE: `start` clears `done` and raises `cpu_reset` for the second image.
